// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N weight-stationary systolic array: optional weight load, M-row
// activation feed, skewed row/column valids and drain, ending in a one-cycle done pulse.
module systolic_ctrl #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned MAX_ROWS   = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [$clog2(MAX_ROWS):0]    num_rows_i,
  input  logic                         reload_weights_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         cfg_err_o,
  output logic                         w_rd_en_o,
  output logic [ADDR_WIDTH-1:0]        w_rd_addr_o,
  output logic [ARRAY_SIZE-1:0]        pe_load_en_o,
  output logic                         a_rd_en_o,
  output logic [ADDR_WIDTH-1:0]        a_rd_addr_o,
  output logic [ARRAY_SIZE-1:0]        row_valid_o,
  output logic                         pe_compute_o,
  output logic [ARRAY_SIZE-1:0]        out_valid_o
);

  localparam int unsigned NumRowsW = $clog2(MAX_ROWS) + 1;
  // One counter serves LOAD (0..N), FEED (0..M-1) and DRAIN (2N-1..0).
  localparam int unsigned CntW     = $clog2(MAX_ROWS + 2 * ARRAY_SIZE + 1);
  localparam int unsigned SrW      = 2 * ARRAY_SIZE;
  localparam logic [ARRAY_SIZE-1:0] Row0 = 1;

  typedef enum logic [2:0] {StIdle, StLoad, StFeed, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NumRowsW-1:0] m_q, m_d;
  logic                reload_q, reload_d;
  logic                cfg_err_q, cfg_err_d;
  // Bit k is high k+1 cycles after an activation read: row valids then column valids.
  logic [SrW-1:0]      sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      m_q       <= '0;
      reload_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      reload_q  <= reload_d;
      cfg_err_q <= cfg_err_d;
      sr_q      <= {sr_q[SrW-2:0], a_rd_en_o};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    reload_d  = reload_q;
    cfg_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (num_rows_i == '0 || num_rows_i > NumRowsW'(MAX_ROWS)) begin
            cfg_err_d = 1'b1;
          end else begin
            m_d      = num_rows_i;
            reload_d = reload_weights_i;
            cnt_d    = '0;
            state_d  = reload_weights_i ? StLoad : StFeed;
          end
        end
      end
      StLoad: begin
        if (cnt_q == CntW'(ARRAY_SIZE)) begin
          cnt_d   = '0;
          state_d = StFeed;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFeed: begin
        if (cnt_q == CntW'(m_q) - CntW'(1)) begin
          cnt_d   = CntW'(2 * ARRAY_SIZE - 1);
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StDone);
    cfg_err_o    = cfg_err_q;
    w_rd_en_o    = (state_q == StLoad) && (cnt_q < CntW'(ARRAY_SIZE));
    w_rd_addr_o  = w_rd_en_o ? ADDR_WIDTH'(cnt_q) : '0;
    pe_load_en_o = '0;
    if (state_q == StLoad && cnt_q != '0) begin
      pe_load_en_o = Row0 << (cnt_q - CntW'(1));
    end
    a_rd_en_o    = (state_q == StFeed);
    a_rd_addr_o  = a_rd_en_o ? ADDR_WIDTH'(cnt_q) : '0;
    row_valid_o  = sr_q[ARRAY_SIZE-1:0];
    out_valid_o  = sr_q[SrW-1:ARRAY_SIZE];
    // Compute stops one cycle before the last column valid: that result is already at the edge.
    pe_compute_o = |sr_q[SrW-2:0];
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the N×N weight-stationary systolic PE array. Each job runs the same steps. It optionally loads weights row by row from the weight buffer. It then streams M data rows from the activation buffer into array row 0. It generates the per-row skew valids, holds `pe_compute` through fill and drain, and flags per-column result validity at the array's bottom edge. It sits between the host command interface and the array/buffer datapath.

## Interface
- `ARRAY_SIZE`, default 4: N, the array dimension (rows = columns).
- `MAX_ROWS`, default 16: maximum M, the data rows per job.
- `ADDR_WIDTH`, default 8: width of the buffer read addresses.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `start` in 1: job request, sampled only in IDLE.
- `num_rows` in $clog2(MAX_ROWS)+1: M, latched on accepted `start`.
- `reload_weights` in 1: latched on `start`; 1 = run LOAD, 0 = reuse resident weights.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle end-of-job pulse.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.
- `w_rd_en` out 1: weight buffer read strobe (buffer has 1-cycle read latency).
- `w_rd_addr` out ADDR_WIDTH: weight row address, 0..N-1.
- `pe_load_en` out N: one-hot row load enable to the array.
- `a_rd_en` out 1: activation buffer read strobe (1-cycle latency).
- `a_rd_addr` out ADDR_WIDTH: data row address, 0..M-1.
- `row_valid` out N: skewed input-valid, one bit per array row.
- `pe_compute` out 1: array-wide compute enable.
- `out_valid` out N: bottom-row partial sum of column c is a valid result.

## Operation
- States: IDLE, LOAD, FEED, DRAIN, DONE.
- IDLE, `start`=1, `num_rows`==0 or > MAX_ROWS: pulse `cfg_err` the next cycle and stay in IDLE.
- IDLE, `start`=1, `num_rows` valid: latch M and `reload_weights`. Go to LOAD if reload=1, else FEED.
- LOAD lasts N+1 cycles:
  - `w_rd_en`=1 with `w_rd_addr`=0..N-1 over the first N cycles.
  - `pe_load_en[r]` is asserted exactly one cycle after the read of address r.
  - The final cycle only flushes read latency, so loading never overlaps `pe_compute`.
- FEED lasts M cycles: `a_rd_en`=1 with `a_rd_addr`=0..M-1. Then go to DRAIN.
- DRAIN: a down-counter runs until the last `out_valid`, then go to DONE.
- DONE lasts 1 cycle: `done`=1, then go to IDLE.
- Define T0 = the cycle after the first `a_rd_en` (first data at array row 0). Per-output windows, all inclusive:
  - `row_valid[r]` is high for cycles T0+r .. T0+r+M-1.
  - `pe_compute` is high for T0 .. T0+M+2N-3.
  - `out_valid[c]` is high for T0+N+c .. T0+N+c+M-1.
  - `done` is at T0+M+2N-1.
- `busy` is high from the cycle after accepted `start` through the DONE cycle inclusive.
- `start` while `busy` is ignored: no `cfg_err`, no effect.
- `start` in the same cycle as `done` is ignored, because the FSM is not yet in IDLE.
- Reset values: all outputs 0, state IDLE, counters 0.
- `rst` mid-job aborts the job on the next edge: all strobes and enables drop to 0 and no `done` is produced.
- Address counters are sized to avoid wrap. M = MAX_ROWS must work: the last address is MAX_ROWS-1 and the counter does not overflow.

## Timing
- Accepted `start` at cycle S with reload=1:
  - `w_rd_en` at S+1..S+N.
  - `pe_load_en` row r at S+2+r.
  - `a_rd_en` at S+N+2..S+N+1+M, so T0 = S+N+3.
- With reload=0: `a_rd_en` starts at S+1, so T0 = S+2.
- Total job latency from `start` to `done`: (N+2 or 1) + 1 + M + 2N-1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Minimum gap between back-to-back jobs: `start` accepted at the cycle after `done`.

## Test plan
- N=4, M=3, reload=1, `start` at cycle 0 -> `w_rd_en` 1..4 (addr 0..3), `pe_load_en` = 0001,0010,0100,1000 at 2..5, `a_rd_en` 6..8, `row_valid[3]` 10..12, `pe_compute` 7..15, `out_valid[0]` 11..13, `out_valid[3]` 14..16, `done` at 17.
- N=4, M=1, reload=0, `start` at 0 -> no `w_rd_en`/`pe_load_en`, `a_rd_en` at 1 only, `out_valid[c]` at 6+c, `done` at 10.
- `num_rows`=0, then `num_rows`=17 (MAX_ROWS=16) -> `cfg_err` pulse each time, `busy` stays 0. Then M=16 -> `a_rd_addr` reaches 15, `done` at T0+23.
- `start` pulsed during FEED and again on the `done` cycle -> both ignored. `start` the following cycle is accepted and the second job repeats identical timing.
- `rst` asserted at T0+2 of an M=5 job -> all outputs 0 on the next cycle, no `done`. A new job afterward runs with nominal timing.
- Random N∈{2,4,8}, M∈1..MAX_ROWS, random reload: scoreboard checks every window formula above, `pe_load_en` never overlaps `pe_compute`, and `pe_load_en` is always one-hot or zero.
